alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter MAX_WAIT, default 15, is the maximum number of EXEC cycles spent waiting on o_alu_stall/i_alu_stall before timeout; legal range 1..15.
REQ-002 i_clk  input  1  single clock; all state updates on posedge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_flush  input  1  synchronous discard of any in-flight operation.
REQ-005 i_in_valid  input  1  upstream offers an operation.
REQ-006 o_in_ready  output  1  block accepts the operation this cycle.
REQ-007 i_in_op  input  4  ALU opcode: bit 3 = ADD/SUB and SRL/SRA select, bits 2:0 = operation.
REQ-008 i_in_a / i_in_b  input  32 each  operands.
REQ-009 i_in_rd  input  5  destination tag, returned with the result.
REQ-010 o_alu_op  output  4  registered opcode driven to the ALU.
REQ-011 o_alu_a / o_alu_b  output  32 each  registered operands driven to the ALU.
REQ-012 i_alu_out  input  32  ALU result.
REQ-013 i_alu_stall  input  1  ALU not ready; result is invalid while high.
REQ-014 o_out_valid  output  1  result available.
REQ-015 i_out_ready  input  1  downstream consumes the result.
REQ-016 o_out_data  output  32  captured result.
REQ-017 o_out_rd  output  5  tag of the captured result.
REQ-018 o_out_err  output  1  result produced by timeout, not by the ALU.

Function
REQ-019 The FSM shall have three states: IDLE, EXEC, HOLD.
REQ-020 IDLE: o_in_ready=1, o_out_valid=0.
- On i_in_valid, latch op/a/b/rd into the o_alu_* registers and the rd register.
- Clear the wait counter and go to EXEC.
REQ-021 EXEC: o_in_ready=0, o_out_valid=0, and the o_alu_* outputs shall hold steady.
- If i_alu_stall=0, capture i_alu_out into o_out_data, set o_out_err=0, and go to HOLD.
REQ-022 EXEC with i_alu_stall=1: increment the 4-bit wait counter.
- If the counter already equals MAX_WAIT, set o_out_data=0 and o_out_err=1, and go to HOLD.
REQ-023 Minimum latency from acceptance to o_out_valid shall be 2 cycles: one EXEC cycle with stall low, then HOLD.
REQ-024 HOLD: o_out_valid=1; o_out_data, o_out_rd and o_out_err shall be stable until consumed; o_in_ready=i_out_ready.
REQ-025 HOLD with i_out_ready=1 and i_in_valid=1: consume the result, accept the new operation in the same cycle, and go directly to EXEC with no bubble.
REQ-026 HOLD with i_out_ready=1 and i_in_valid=0: go to IDLE.
REQ-027 HOLD with i_out_ready=0: remain in HOLD; o_in_ready=0.
REQ-028 i_flush=1 in any state: next state IDLE, o_out_valid deasserts next cycle, no acceptance that cycle (o_in_ready=0), counter cleared.
- Flush has priority over every other transition.
REQ-029 o_in_ready and o_out_valid shall depend combinationally on state, i_flush and i_out_ready only, never on i_in_valid.
REQ-030 Exactly one result shall be emitted per accepted, unflushed operation, in order.
REQ-031 The wait counter shall saturate and never wrap.
REQ-032 o_out_rd shall equal the i_in_rd latched at acceptance.

Reset
REQ-033 While i_rst_n=0, all registers shall clear immediately (asynchronously): state IDLE, o_alu_op/a/b=0, o_out_data=0, o_out_rd=0, o_out_err=0, counter=0.
REQ-034 While i_rst_n=0, o_in_ready=0 and o_out_valid=0.
REQ-035 The first acceptance shall occur no earlier than the first posedge after i_rst_n rises.
REQ-036 Reset asserted mid-EXEC or mid-HOLD shall discard the operation; no result shall appear after release.

Verification
REQ-037 ADD 5+7, rd=3, i_alu_stall=0 throughout -> o_out_valid two cycles after acceptance, data=12, rd=3, err=0.
REQ-038 SUB (op=4'b1000) 5-7 with i_alu_stall toggling 1,0 -> one extra EXEC cycle, data=32'hFFFFFFFE, err=0.
REQ-039 i_alu_stall held 1, MAX_WAIT=15 -> o_out_valid after 16 EXEC cycles, data=0, err=1.
REQ-040 Back-to-back stream of 4 ops with i_out_ready=1, stall=0 -> one result per EXEC/HOLD pair, no bubble between ops, tags in order.
REQ-041 i_out_ready=0 for 5 cycles in HOLD -> o_out_data stable and o_in_ready=0 throughout; then i_out_ready=1 -> consumed exactly once.
REQ-042 i_flush during EXEC, and separately i_rst_n=0 during HOLD -> IDLE next cycle (flush) or immediately (reset), no result emitted, next op processes correctly.

Source files
------------

// File: rtl/alu_issue.sv
// Single-entry issue stage between an operand source and a multi-cycle ALU.
// Accepts one op, waits out ALU stalls (with timeout), and holds the tagged result until consumed.
module alu_issue #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [3:0]  i_in_op,
   input  logic [31:0] i_in_a,
   input  logic [31:0] i_in_b,
   input  logic [4:0]  i_in_rd,
   output logic [3:0]  o_alu_op,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   input  logic [31:0] i_alu_out,
   input  logic        i_alu_stall,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_data,
   output logic [4:0]  o_out_rd,
   output logic        o_out_err
);

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   rd_q;
   logic            accept, capture, timeout;

   // Next state, handshake outputs and datapath enables; flush overrides everything
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      accept      = 1'b0;
      capture     = 1'b0;
      timeout     = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!i_alu_stall) begin
               capture = 1'b1;
               state_d = S_HOLD;
            end else if (cnt_q == CW'(MAX_WAIT)) begin
               timeout = 1'b1;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            o_out_valid = 1'b1;
            o_in_ready  = i_out_ready;
            if (i_out_ready) begin
               if (i_in_valid) begin
                  accept  = 1'b1;
                  cnt_d   = '0;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (i_flush) begin
         state_d     = S_IDLE;
         cnt_d       = '0;
         o_in_ready  = 1'b0;
         o_out_valid = 1'b0;
         accept      = 1'b0;
         capture     = 1'b0;
         timeout     = 1'b0;
      end
      // The register is already IDLE under reset; keep the handshake closed too
      if (!i_rst_n) begin
         o_in_ready  = 1'b0;
         o_out_valid = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Operand/tag capture at acceptance, result capture on ALU completion or timeout
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_alu_op   <= '0;
         o_alu_a    <= '0;
         o_alu_b    <= '0;
         rd_q       <= '0;
         o_out_data <= '0;
         o_out_rd   <= '0;
         o_out_err  <= 1'b0;
      end else begin
         if (accept) begin
            o_alu_op <= i_in_op;
            o_alu_a  <= i_in_a;
            o_alu_b  <= i_in_b;
            rd_q     <= i_in_rd;
         end
         if (capture) begin
            o_out_data <= i_alu_out;
            o_out_rd   <= rd_q;
            o_out_err  <= 1'b0;
         end else if (timeout) begin
            o_out_data <= DW'(0);
            o_out_rd   <= rd_q;
            o_out_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: transaction-level model of the issue slot plus a behavioural ALU,
// directed op sequences with hand-computed results and latencies.
module tb_alu_issue;
   localparam int unsigned MAXW = 15;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_flush, i_in_valid, o_in_ready;
   logic [3:0]  i_in_op, o_alu_op;
   logic [31:0] i_in_a, i_in_b, o_alu_a, o_alu_b, i_alu_out, o_out_data;
   logic [4:0]  i_in_rd, o_out_rd;
   logic        i_alu_stall, o_out_valid, i_out_ready, o_out_err;

   always #5 i_clk = ~i_clk;

   alu_issue #(.MAX_WAIT(MAXW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_in_op(i_in_op), .i_in_a(i_in_a), .i_in_b(i_in_b), .i_in_rd(i_in_rd),
      .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
      .i_alu_out(i_alu_out), .i_alu_stall(i_alu_stall),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_out_data(o_out_data), .o_out_rd(o_out_rd), .o_out_err(o_out_err)
   );

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic [31:0] r;
      sa = a;
      case (op[2:0])
         3'd0: r = op[3] ? a - b : a + b;
         3'd1: r = a << b[4:0];
         3'd2: r = {31'd0, sa < $signed(b)};
         3'd3: r = {31'd0, a < b};
         3'd4: r = a ^ b;
         3'd5: begin
            if (op[3]) r = sa >>> b[4:0];
            else       r = a >> b[4:0];
         end
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // Behavioural ALU; garbage while stalled so a premature capture shows up
   assign i_alu_out = i_alu_stall ? 32'hDEAD_BEEF : alu_f(o_alu_op, o_alu_a, o_alu_b);

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      int          nstall;
   } op_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        err;
      int          lat;
      int          vcyc;
   } res_t;

   op_t  stim_q[$];
   res_t log_q[$];

   // Model: one slot, either executing (m_busy) or holding a result (m_has)
   bit          m_busy, m_has;
   op_t         m_cur;
   int          m_stalled, m_stall_left, m_accept_cyc, m_valid_cyc, m_lat;
   logic [31:0] m_data;
   logic [4:0]  m_rd;
   logic        m_err;
   int          cyc, hold_cnt;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit exp_ready();
      return i_rst_n && !i_flush && (m_has ? i_out_ready : !m_busy);
   endfunction

   function automatic bit exp_valid();
      return i_rst_n && !i_flush && m_has;
   endfunction

   task automatic drive();
      i_in_valid = stim_q.size() > 0;
      if (stim_q.size() > 0) begin
         i_in_op = stim_q[0].op;
         i_in_a  = stim_q[0].a;
         i_in_b  = stim_q[0].b;
         i_in_rd = stim_q[0].rd;
      end else begin
         i_in_op = 4'($urandom);
         i_in_a  = $urandom;
         i_in_b  = $urandom;
         i_in_rd = 5'($urandom);
      end
      i_out_ready = (hold_cnt == 0);
      i_alu_stall = m_busy && (m_stall_left > 0);
   endtask

   task automatic compare();
      chk("in_ready", 32'(o_in_ready), 32'(exp_ready()));
      chk("out_valid", 32'(o_out_valid), 32'(exp_valid()));
      if (exp_valid()) begin
         chk("out_data", o_out_data, m_data);
         chk("out_rd", 32'(o_out_rd), 32'(m_rd));
         chk("out_err", 32'(o_out_err), 32'(m_err));
         if (i_out_ready)
            log_q.push_back('{data: o_out_data, rd: o_out_rd, err: o_out_err, lat: m_lat, vcyc: m_valid_cyc});
      end
      if (i_rst_n && m_busy) begin
         chk("alu_op", 32'(o_alu_op), 32'(m_cur.op));
         chk("alu_a", o_alu_a, m_cur.a);
         chk("alu_b", o_alu_b, m_cur.b);
      end
   endtask

   task automatic update();
      bit acc;
      acc = exp_ready() && i_in_valid;
      if (!i_rst_n || i_flush) begin
         m_busy = 0;
         m_has  = 0;
      end else begin
         if (m_has && i_out_ready) m_has = 0;
         if (m_busy) begin
            if (m_stall_left == 0) begin
               m_busy = 0; m_has = 1;
               m_data = alu_f(m_cur.op, m_cur.a, m_cur.b);
               m_err  = 1'b0;
            end else begin
               m_stalled++;
               m_stall_left--;
               if (m_stalled == MAXW + 1) begin
                  m_busy = 0; m_has = 1;
                  m_data = '0;
                  m_err  = 1'b1;
               end
            end
            if (m_has) begin
               m_rd        = m_cur.rd;
               m_valid_cyc = cyc + 1;
               m_lat       = m_valid_cyc - m_accept_cyc;
            end
         end
         if (acc) begin
            m_cur        = stim_q.pop_front();
            m_busy       = 1;
            m_stall_left = m_cur.nstall;
            m_stalled    = 0;
            m_accept_cyc = cyc;
         end
      end
   endtask

   task automatic cycle();
      bit dec;
      drive();
      #1;
      compare();
      dec = exp_valid() && hold_cnt > 0;
      @(posedge i_clk);
      update();
      if (dec) hold_cnt--;
      cyc++;
      @(negedge i_clk);
   endtask

   task automatic run();
      int n = 0;
      while ((stim_q.size() > 0 || m_busy || m_has) && n < 200) begin
         cycle();
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL run_bound: still busy after %0d cycles", n);
      end
      cycle();
   endtask

   task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int nstall);
      stim_q.push_back('{op: op, a: a, b: b, rd: rd, nstall: nstall});
   endtask

   task automatic check_log(input string t, input int idx, input logic [31:0] data,
                            input logic [4:0] rd, input logic err, input int lat);
      checks++;
      if (idx >= log_q.size()) begin
         errors++;
         $display("FAIL %s.present: results %0d required index %0d", t, log_q.size(), idx);
      end else begin
         chk({t, ".data"}, log_q[idx].data, data);
         chk({t, ".rd"}, 32'(log_q[idx].rd), 32'(rd));
         chk({t, ".err"}, 32'(log_q[idx].err), 32'(err));
         chk({t, ".lat"}, 32'(log_q[idx].lat), 32'(lat));
      end
   endtask

   initial begin
      int base;
      int n;
      i_rst_n = 1'b0; i_flush = 1'b0; hold_cnt = 0; cyc = 0;
      m_busy = 0; m_has = 0;
      i_in_valid = 1'b0; i_in_op = '0; i_in_a = '0; i_in_b = '0; i_in_rd = '0;
      i_out_ready = 1'b1; i_alu_stall = 1'b0;
      #2;
      chk("rst.in_ready", 32'(o_in_ready), 32'd0);
      chk("rst.out_valid", 32'(o_out_valid), 32'd0);
      chk("rst.alu_op", 32'(o_alu_op), 32'd0);
      chk("rst.alu_a", o_alu_a, 32'd0);
      chk("rst.out_data", o_out_data, 32'd0);
      chk("rst.out_rd", 32'(o_out_rd), 32'd0);
      chk("rst.out_err", 32'(o_out_err), 32'd0);
      @(negedge i_clk);

      // ADD 5+7 offered during reset: must wait for release
      push(4'b0000, 32'd5, 32'd7, 5'd3, 0);
      cycle();
      cycle();
      i_rst_n = 1'b1;
      base = log_q.size();
      run();
      check_log("add", base, 32'd12, 5'd3, 1'b0, 2);

      base = log_q.size();
      push(4'b1000, 32'd5, 32'd7, 5'd9, 1);
      run();
      check_log("sub_stall", base, 32'hFFFF_FFFE, 5'd9, 1'b0, 3);

      base = log_q.size();
      push(4'b0111, 32'h0000_FFFF, 32'h0000_00FF, 5'd17, 20);
      run();
      check_log("timeout", base, 32'd0, 5'd17, 1'b1, 17);

      base = log_q.size();
      push(4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 5'd21, 15);
      run();
      check_log("stall15", base, 32'h0000_FF00, 5'd21, 1'b0, 17);

      // Back-to-back stream with the consumer always ready
      base = log_q.size();
      push(4'b0110, 32'h0000_0F00, 32'h0000_00F0, 5'd1, 0);
      push(4'b1101, 32'h8000_0000, 32'd4, 5'd2, 0);
      push(4'b0001, 32'd1, 32'd5, 5'd3, 0);
      push(4'b0011, 32'd3, 32'd4, 5'd4, 0);
      run();
      check_log("s0", base, 32'h0000_0FF0, 5'd1, 1'b0, 2);
      check_log("s1", base + 1, 32'hF800_0000, 5'd2, 1'b0, 2);
      check_log("s2", base + 2, 32'd32, 5'd3, 1'b0, 2);
      check_log("s3", base + 3, 32'd1, 5'd4, 1'b0, 2);
      if (log_q.size() >= base + 4)
         for (int i = 1; i < 4; i++)
            chk($sformatf("s%0d.spacing", i), 32'(log_q[base+i].vcyc - log_q[base+i-1].vcyc), 32'd2);

      // Consumer stalls for 5 cycles in HOLD
      base = log_q.size();
      push(4'b0000, 32'd100, 32'd23, 5'd7, 0);
      hold_cnt = 5;
      run();
      chk("hold.count", 32'(log_q.size() - base), 32'd1);
      check_log("hold", base, 32'd123, 5'd7, 1'b0, 2);

      // Flush during EXEC with the next op already offered
      base = log_q.size();
      push(4'b1000, 32'd50, 32'd8, 5'd11, 3);
      n = 0;
      while (!m_busy && n < 10) begin cycle(); n++; end
      cycle();
      push(4'b0000, 32'd1, 32'd2, 5'd5, 0);
      i_flush = 1'b1;
      cycle();
      i_flush = 1'b0;
      run();
      chk("flush.count", 32'(log_q.size() - base), 32'd1);
      check_log("after_flush", base, 32'd3, 5'd5, 1'b0, 2);

      // Asynchronous reset while holding a result
      base = log_q.size();
      push(4'b0000, 32'd9, 32'd9, 5'd30, 0);
      hold_cnt = 50;
      n = 0;
      while (!m_has && n < 10) begin cycle(); n++; end
      #2 i_rst_n = 1'b0;
      #1;
      chk("arst.out_valid", 32'(o_out_valid), 32'd0);
      chk("arst.in_ready", 32'(o_in_ready), 32'd0);
      chk("arst.out_data", o_out_data, 32'd0);
      chk("arst.out_rd", 32'(o_out_rd), 32'd0);
      @(negedge i_clk);
      cycle();
      i_rst_n = 1'b1;
      hold_cnt = 0;
      run();
      chk("arst.count", 32'(log_q.size() - base), 32'd0);
      push(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd6, 0);
      run();
      check_log("after_rst", base, 32'd1, 5'd6, 1'b0, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
